data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder.sv | 160 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-memory responder for the control unit's RD/WR interface.
// Level-held requests are accepted in IDLE, delayed by WAIT_STATES cycles, performed on a
// word-addressed array and answered with a one-cycle ACK (plus error flag), after which the
// responder waits for the request to be released before accepting another.
// Optional build macro DATAMEM_CLEAR_ON_RESET_EN: reset zero-fills the array, one word per
// cycle, before the responder becomes available.
module data_memory_responder #(
  parameter int unsigned DATAWIDTH_BUS      = 32,
  parameter int unsigned DATAWIDTH_MEM_ADDR = 8,
  parameter int unsigned WAIT_STATES        = 2,
  parameter int unsigned DATAWIDTH_WAIT     = 4
) (
  input  logic                     DataMemoryResp_CLOCK_50,
  input  logic                     DataMemoryResp_RESET_InHigh,
  input  logic                     DataMemoryResp_Selector_RD,
  input  logic                     DataMemoryResp_Selector_WR,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryResp_Address_In,
  input  logic [DATAWIDTH_BUS-1:0] DataMemoryResp_Data_In,
  output logic [DATAWIDTH_BUS-1:0] DataMemoryResp_Data_Out,
  output logic                     DataMemoryResp_Ack_Out,
  output logic                     DataMemoryResp_Error_Out,
  output logic                     DataMemoryResp_Busy_Out
);

`ifdef DATAMEM_CLEAR_ON_RESET_EN
  typedef enum logic [2:0] {StIdle, StWait, StAck, StRelease, StClear} state_e;
`else
  typedef enum logic [2:0] {StIdle, StWait, StAck, StRelease} state_e;
`endif

  state_e                          r_state;
  state_e                          w_state_next;
  logic [DATAWIDTH_WAIT-1:0]       r_count;
  logic [DATAWIDTH_MEM_ADDR-1:0]   r_idx;
  logic [DATAWIDTH_BUS-1:0]        r_wdata;
  logic                            r_op_wr;
  logic                            r_invalid;
  logic [DATAWIDTH_BUS-1:0]        r_data_out;
  logic                            r_error;
  logic [DATAWIDTH_BUS-1:0]        r_mem [2**DATAWIDTH_MEM_ADDR];

  logic                            w_req;
  logic                            w_accept;
  logic                            w_invalid_in;
  logic                            w_wait_done;
  logic                            w_mem_we;
  logic [DATAWIDTH_MEM_ADDR-1:0]   w_mem_idx;
  logic [DATAWIDTH_BUS-1:0]        w_mem_wdata;
  logic                            w_unused_addr;

`ifdef DATAMEM_CLEAR_ON_RESET_EN
  logic [DATAWIDTH_MEM_ADDR-1:0]   r_clr_idx;
`endif

  assign w_req        = DataMemoryResp_Selector_RD | DataMemoryResp_Selector_WR;
  assign w_accept     = (r_state == StIdle) && w_req;
  // Conflicting strobes or a non-word-aligned byte address are rejected.
  assign w_invalid_in = (DataMemoryResp_Selector_RD & DataMemoryResp_Selector_WR) |
                        (DataMemoryResp_Address_In[1:0] != 2'b00);
  assign w_wait_done  = (r_state == StWait) && (r_count == '0);
  // Upper address bits alias onto the array by design.
  assign w_unused_addr = ^DataMemoryResp_Address_In[DATAWIDTH_BUS-1:DATAWIDTH_MEM_ADDR+2];

  // State register; reset returns to IDLE (or starts the clear walk).
  always_ff @(posedge DataMemoryResp_CLOCK_50) begin
    if (DataMemoryResp_RESET_InHigh) begin
`ifdef DATAMEM_CLEAR_ON_RESET_EN
      r_state <= StClear;
`else
      r_state <= StIdle;
`endif
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and array write-port selection.
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_idx    = r_idx;
    w_mem_wdata  = r_wdata;
    unique case (r_state)
      StIdle:    if (w_req) w_state_next = StWait;
      StWait:    if (r_count == '0) w_state_next = StAck;
      StAck:     w_state_next = w_req ? StRelease : StIdle;
      StRelease: if (!w_req) w_state_next = StIdle;
`ifdef DATAMEM_CLEAR_ON_RESET_EN
      StClear:   if (&r_clr_idx) w_state_next = StIdle;
`endif
      default:   w_state_next = StIdle;
    endcase
    if (w_wait_done && r_op_wr && !r_invalid) begin
      w_mem_we = 1'b1;
    end
`ifdef DATAMEM_CLEAR_ON_RESET_EN
    if (r_state == StClear) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_clr_idx;
      w_mem_wdata = '0;
    end
`endif
    // A pending write is dropped if reset lands on its completion edge.
    if (DataMemoryResp_RESET_InHigh) begin
      w_mem_we = 1'b0;
    end
  end

  // Request capture, wait counter, read data and error flag.
  always_ff @(posedge DataMemoryResp_CLOCK_50) begin
    if (DataMemoryResp_RESET_InHigh) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_op_wr    <= 1'b0;
      r_invalid  <= 1'b0;
      r_data_out <= '0;
      r_error    <= 1'b0;
    end else if (w_accept) begin
      r_idx     <= DataMemoryResp_Address_In[DATAWIDTH_MEM_ADDR+1:2];
      r_wdata   <= DataMemoryResp_Data_In;
      r_op_wr   <= DataMemoryResp_Selector_WR;
      r_invalid <= w_invalid_in;
      r_count   <= DATAWIDTH_WAIT'(WAIT_STATES);
      r_error   <= 1'b0;
    end else if (r_state == StWait) begin
      if (r_count != '0) begin
        r_count <= r_count - 1'b1;
      end else if (r_invalid) begin
        r_error <= 1'b1;
      end else if (!r_op_wr) begin
        r_data_out <= r_mem[r_idx];
      end
    end
  end

`ifdef DATAMEM_CLEAR_ON_RESET_EN
  // Clear-walk index; restarts from word 0 on every reset.
  always_ff @(posedge DataMemoryResp_CLOCK_50) begin
    if (DataMemoryResp_RESET_InHigh) begin
      r_clr_idx <= '0;
    end else if (r_state == StClear) begin
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end
`endif

  // Array write port; contents are not touched by reset itself.
  always_ff @(posedge DataMemoryResp_CLOCK_50) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  assign DataMemoryResp_Data_Out  = r_data_out;
  assign DataMemoryResp_Error_Out = r_error;
  assign DataMemoryResp_Ack_Out   = (r_state == StAck);
  assign DataMemoryResp_Busy_Out  = (r_state != StIdle);

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed plan steps followed by randomized
// transactions, all checked against an array-based reference model of the memory.
module tb_data_memory_responder;
  localparam int unsigned WS = 2;
  localparam int unsigned AW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
  logic        err;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] m_mem [2**AW];
  logic [31:0] m_dout;
  logic        m_err;

  data_memory_responder #(
    .DATAWIDTH_BUS      (32),
    .DATAWIDTH_MEM_ADDR (AW),
    .WAIT_STATES        (WS),
    .DATAWIDTH_WAIT     (4)
  ) dut (
    .DataMemoryResp_CLOCK_50     (clk),
    .DataMemoryResp_RESET_InHigh (rst),
    .DataMemoryResp_Selector_RD  (rd),
    .DataMemoryResp_Selector_WR  (wr),
    .DataMemoryResp_Address_In   (addr),
    .DataMemoryResp_Data_In      (din),
    .DataMemoryResp_Data_Out     (dout),
    .DataMemoryResp_Ack_Out      (ack),
    .DataMemoryResp_Error_Out    (err),
    .DataMemoryResp_Busy_Out     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full handshake: present request, expect ACK WS+1 edges after acceptance,
  // optionally keep it held for 'hold' cycles, then release.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    logic        e;
    logic [31:0] lat;
    bit          seen;
    logic [31:0] noise;
    e = (r && w) || (a[1:0] != 2'b00);
    rd = r; wr = w; addr = a; din = d;
    step();
    check("accept_ack_busy", {30'd0, ack, busy}, 32'd1);
    lat = 0; seen = 0;
    for (int i = 1; i <= int'(WS) + 6 && !seen; i++) begin
      noise = $urandom; addr = noise;
      noise = $urandom; din = noise;
      step();
      if (ack) begin seen = 1; lat = i; end
    end
    check("ack_latency", lat, WS + 1);
    if (!e) begin
      if (w) m_mem[a[AW+1:2]] = d;
      else   m_dout = m_mem[a[AW+1:2]];
    end
    m_err = e;
    if (seen) begin
      check("ack_error", {31'd0, err}, {31'd0, m_err});
      check("ack_data_out", dout, m_dout);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      check("held_no_second_ack", {30'd0, ack, busy}, 32'd1);
    end
    rd = 0; wr = 0;
    step();
    check("idle_ack_busy", {30'd0, ack, busy}, 32'd0);
    check("idle_error_hold", {31'd0, err}, {31'd0, m_err});
    check("idle_data_hold", dout, m_dout);
  endtask

  // Assert reset for two edges with requests low, then release it.
  task automatic do_reset(input logic hold_rd);
    rst = 1; rd = 0; wr = 0;
    step();
    step();
    m_dout = '0;
    m_err  = 1'b0;
    check("rst_data_out", dout, 32'd0);
    check("rst_ack_err", {30'd0, ack, err}, 32'd0);
`ifdef DATAMEM_CLEAR_ON_RESET_EN
    check("rst_busy", {31'd0, busy}, 32'd1);
    rst = 0; rd = hold_rd;
    for (int i = 0; i < (1 << AW); i++) begin
      step();
      check("clear_busy", {30'd0, ack, busy}, (i < (1 << AW) - 1) ? 32'd1 : 32'd0);
    end
    rd = 0;
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
`else
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 0; rd = hold_rd;
    step();
    rd = 0;
    check("post_rst_ack", {30'd0, ack, busy}, 32'd0);
    // A request held right after reset was accepted; let it finish and drop it.
    for (int i = 0; i < int'(WS) + 4; i++) step();
    if (hold_rd) begin
      check("post_rst_release", {30'd0, ack, busy}, 32'd0);
    end
`endif
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rdat;
    int          kind;
    rst = 1; rd = 0; wr = 0; addr = '0; din = '0;
    m_dout = '0; m_err = 1'b0;
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;

`ifdef DATAMEM_CLEAR_ON_RESET_EN
    do_reset(1'b1);
`else
    do_reset(1'b0);
`endif

    // Give every word a known value so the model covers the whole array.
    for (int i = 0; i < (1 << AW); i++) begin
      rdat = $urandom;
      do_req(1'b0, 1'b1, 32'(i * 4), rdat, 0);
    end

    // Write then read.
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 0);
    check("plan_read_back", dout, 32'hDEADBEEF);

    // Misaligned write and conflicting strobes.
    do_req(1'b0, 1'b1, 32'h13, 32'h01020304, 0);
    check("plan_misaligned_err", {31'd0, err}, 32'd1);
    do_req(1'b1, 1'b1, 32'h10, 32'h55555555, 0);
    check("plan_conflict_err", {31'd0, err}, 32'd1);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 0);
    check("plan_after_err_read", dout, 32'hDEADBEEF);

    // Held request: single ACK, busy until release.
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 10);

    // Aliasing of upper address bits.
    do_req(1'b0, 1'b1, 32'h400, 32'h12345678, 0);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 0);
    check("plan_alias_read", dout, 32'h12345678);

    // Reset one cycle after a write is accepted: the write must be lost.
    rd = 0; wr = 1; addr = 32'h20; din = 32'hAAAA5555;
    step();
    check("midwait_accept", {31'd0, busy}, 32'd1);
    rst = 1; wr = 0;
    step();
    check("midwait_reset_outputs", {dout[29:0], ack, err}, 32'd0);
    do_reset(1'b0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 0);

    // Randomized transactions.
    for (int t = 0; t < 80; t++) begin
      kind = int'($urandom_range(0, 9));
      ra = $urandom;
      if (kind < 8) ra[1:0] = 2'b00;
      rdat = $urandom;
      if (kind == 9)      do_req(1'b1, 1'b1, ra, rdat, int'($urandom_range(0, 3)));
      else if (kind < 4)  do_req(1'b0, 1'b1, ra, rdat, int'($urandom_range(0, 3)));
      else                do_req(1'b1, 1'b0, ra, rdat, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
